// File: rtl/cipher_serializer.sv
// Byte serializer for ciphertext blocks: latches a block, emits it MSB byte first
// over a valid/ready handshake, and pulses key_adv on accept and done on completion.
`ifndef MSG_SIZE
`define MSG_SIZE 32
`endif

module cipher_serializer #(
   parameter int MSG_SIZE = `MSG_SIZE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [MSG_SIZE-1:0] din,
   output logic                busy,
   output logic                key_adv,
   output logic [7:0]          byte_out,
   output logic                byte_valid,
   input  logic                byte_ready,
   output logic                byte_last,
   output logic                done
);

   localparam int NBYTES = MSG_SIZE / 8;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q;
   logic [MSG_SIZE-1:0] sreg_q;
   logic [CW-1:0]       cnt_q;
   logic                key_adv_q;
   logic                done_q;
   logic                handshake;

   assign handshake = (state_q == SEND) && byte_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         cnt_q     <= '0;
         key_adv_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         key_adv_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load) begin
                  sreg_q    <= din;
                  cnt_q     <= '0;
                  state_q   <= SEND;
                  key_adv_q <= 1'b1;
               end
            end
            SEND: begin
               // load is deliberately not looked at here, even on the final handshake
               if (handshake) begin
                  if (cnt_q == LAST_CNT) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     sreg_q  <= '0;
                     done_q  <= 1'b1;
                  end else begin
                     sreg_q <= {sreg_q[MSG_SIZE-9:0], 8'h00};
                     cnt_q  <= cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign byte_valid = (state_q == SEND);
   assign busy       = (state_q == SEND);
   assign byte_out   = (state_q == SEND) ? sreg_q[MSG_SIZE-1:MSG_SIZE-8] : 8'h00;
   assign byte_last  = byte_valid && (cnt_q == LAST_CNT);
   assign key_adv    = key_adv_q;
   assign done       = done_q;

endmodule

// File: tb/tb_cipher_serializer.sv
// Bench for cipher_serializer: directed scenarios plus random traffic against a
// block/byte-index reference model and a byte-stream scoreboard.
module tb_cipher_serializer;

   localparam int MS = 32;
   localparam int NB = MS / 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          load = 1'b0;
   logic [MS-1:0] din = '0;
   logic          byte_ready = 1'b0;
   logic          busy, key_adv, byte_valid, byte_last, done;
   logic [7:0]    byte_out;

   cipher_serializer #(.MSG_SIZE(MS)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .din        (din),
      .busy       (busy),
      .key_adv    (key_adv),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last),
      .done       (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model: the block in flight as a byte array plus index of the current byte
   logic [7:0] m_bytes [NB];
   bit         m_busy = 0;
   int         m_idx = 0;
   bit         m_kadv = 0;
   bit         m_done = 0;
   logic [7:0] exp_q [$];
   int         kadv_cnt = 0;
   int         done_cnt = 0;
   bit         prev_kadv = 0;
   bit         prev_done = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      bit         hs;
      logic [7:0] hb;
      hs = byte_valid && byte_ready && reset;
      hb = byte_out;
      if (!reset) begin
         m_busy = 0; m_idx = 0; m_kadv = 0; m_done = 0;
         exp_q.delete();
      end else begin
         m_kadv = 0; m_done = 0;
         if (!m_busy) begin
            if (load) begin
               for (int i = 0; i < NB; i++) begin
                  m_bytes[i] = din[MS-1-8*i -: 8];
                  exp_q.push_back(din[MS-1-8*i -: 8]);
               end
               m_busy = 1; m_idx = 0; m_kadv = 1;
               $display("accept block %08h", din);
            end
         end else if (byte_ready) begin
            if (m_idx == NB - 1) begin
               m_busy = 0; m_idx = 0; m_done = 1;
            end else begin
               m_idx++;
            end
         end
      end
      @(posedge clk);
      #1;
      if (hs) begin
         $display("byte %02h sent", hb);
         check("sb_avail", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("sb_byte", hb, exp_q.pop_front());
      end
      check("busy", busy, m_busy);
      check("byte_valid", byte_valid, m_busy);
      check("byte_out", byte_out, m_busy ? m_bytes[m_idx] : 8'h00);
      check("byte_last", byte_last, m_busy && (m_idx == NB - 1));
      check("key_adv", key_adv, m_kadv);
      check("done", done, m_done);
      check("no_kadv_done_overlap", key_adv && done, 0);
      check("kadv_single", prev_kadv && key_adv, 0);
      check("done_single", prev_done && done, 0);
      prev_kadv = key_adv;
      prev_done = done;
      if (key_adv) kadv_cnt++;
      if (done) begin
         done_cnt++;
         $display("block done");
      end
   endtask

   int k0, d0;
   bit toggle_pat [4] = '{1, 0, 0, 1};

   initial begin
      // reset state
      reset = 0;
      step(); step();
      check("rst_busy", busy, 0);
      check("rst_byte_out", byte_out, 8'h00);
      check("rst_valid", byte_valid, 0);

      // basic block with ready held high
      reset = 1; load = 1; din = 32'h41424344; byte_ready = 1;
      k0 = kadv_cnt; d0 = done_cnt;
      step();
      load = 0; din = 32'h0;
      check("first_byte", byte_out, 8'h41);
      for (int i = 0; i < 6; i++) step();
      check("t1_kadv", kadv_cnt - k0, 1);
      check("t1_done", done_cnt - d0, 1);

      // ready toggling 1,0,0,1
      load = 1; din = 32'h41424344; byte_ready = 1;
      k0 = kadv_cnt; d0 = done_cnt;
      step();
      load = 0;
      for (int i = 0; i < 14; i++) begin
         byte_ready = toggle_pat[i % 4];
         step();
      end
      byte_ready = 1;
      for (int i = 0; i < 4; i++) step();
      check("t2_done", done_cnt - d0, 1);

      // load held with din changing after acceptance
      load = 1; din = 32'h41424344; byte_ready = 1;
      k0 = kadv_cnt; d0 = done_cnt;
      step();
      din = 32'h45464748;
      for (int i = 0; i < 8; i++) step();
      load = 0;
      for (int i = 0; i < 4; i++) step();
      check("t3_kadv", kadv_cnt - k0, 2);
      check("t3_done", done_cnt - d0, 2);

      // reset mid-block after byte 42 accepted
      load = 1; din = 32'h41424344; byte_ready = 1;
      d0 = done_cnt;
      step();
      load = 0;
      step(); step();
      reset = 0;
      step();
      check("t4_busy", busy, 0);
      check("t4_byte_out", byte_out, 8'h00);
      check("t4_no_done", done_cnt - d0, 0);
      reset = 1; load = 1; din = 32'h01020304;
      step();
      load = 0;
      check("t4_new_first", byte_out, 8'h01);
      for (int i = 0; i < 5; i++) step();
      check("t4_new_done", done_cnt - d0, 1);

      // load only during the final handshake cycle
      load = 1; din = 32'h41424344; byte_ready = 1;
      k0 = kadv_cnt;
      step();
      load = 0;
      for (int i = 0; i < 10 && !byte_last; i++) step();
      check("t5_at_last", byte_last, 1);
      load = 1;
      step();
      load = 0;
      for (int i = 0; i < 3; i++) step();
      check("t5_busy", busy, 0);
      check("t5_kadv", kadv_cnt - k0, 1);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         reset      = ($urandom_range(0, 99) != 0);
         load       = ($urandom_range(0, 3) == 0);
         byte_ready = ($urandom_range(0, 2) != 0);
         din        = $urandom;
         step();
      end
      reset = 1; load = 0; byte_ready = 1;
      for (int i = 0; i < 6; i++) step();
      check("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
